// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bundle plus the two ID-stage read ports of the register file.
// count_load/count_load_value preload the debug commit counter for bring-up and test.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [DATA_W-1:0] wb_mem_data;
    logic [DATA_W-1:0] wb_alu_out;
    logic [DATA_W-1:0] wb_pc_add4;
    logic [ADDR_W-1:0] wb_write_reg;
    logic              wb_reg_write;
    logic [1:0]        wb_mem_to_reg;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic              wb_commit;
    logic [31:0]       commit_count;
    logic              count_load;
    logic [31:0]       count_load_value;

    modport master (
        output wb_mem_data, wb_alu_out, wb_pc_add4, wb_write_reg, wb_reg_write,
               wb_mem_to_reg, rs_addr, rt_addr, count_load, count_load_value,
        input  rs_data, rt_data, wb_data, wb_commit, commit_count
    );

    modport slave (
        input  wb_mem_data, wb_alu_out, wb_pc_add4, wb_write_reg, wb_reg_write,
               wb_mem_to_reg, rs_addr, rt_addr, count_load, count_load_value,
        output rs_data, rt_data, wb_data, wb_commit, commit_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select, 32-entry architectural register file with write-through
// read bypass, and a free-running committed-write counter for debug.
module wb_regfile #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned WRITE_THROUGH = 1
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int unsigned NREGS  = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = 32;
    localparam bit          BYPASS = (WRITE_THROUGH != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] wb_data;
    logic              commit;
    logic              rs_bypass;
    logic              rt_bypass;
    logic [CNT_W-1:0]  count_q;

    // Write-back source mux; encoding 11 is reserved and aliases the ALU result.
    always_comb begin
        wb_data = bus.wb_alu_out;
        case (bus.wb_mem_to_reg)
            2'b01:   wb_data = bus.wb_mem_data;
            2'b10:   wb_data = bus.wb_pc_add4;
            default: wb_data = bus.wb_alu_out;
        endcase
    end

    assign commit = bus.wb_reg_write && (bus.wb_write_reg != ADDR_W'(0));

    // Storage; entry 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.wb_write_reg] <= wb_data;
        end
    end

    // Bypass is suppressed in reset so both ports read zero while it is held.
    assign rs_bypass = BYPASS && !reset && commit && (bus.rs_addr == bus.wb_write_reg);
    assign rt_bypass = BYPASS && !reset && commit && (bus.rt_addr == bus.wb_write_reg);

    always_comb begin
        bus.rs_data = '0;
        if (bus.rs_addr != ADDR_W'(0)) begin
            bus.rs_data = rs_bypass ? wb_data : regs[bus.rs_addr];
        end
    end

    always_comb begin
        bus.rt_data = '0;
        if (bus.rt_addr != ADDR_W'(0)) begin
            bus.rt_data = rt_bypass ? wb_data : regs[bus.rt_addr];
        end
    end

    // Committed-write counter; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (bus.count_load) begin
            count_q <= bus.count_load_value;
        end else if (commit) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.wb_data      = wb_data;
    assign bus.wb_commit    = commit;
    assign bus.commit_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a vector table for select/commit/read behaviour,
// plus sequences for write-through vs. stored reads, async reset and counter wrap.
module tb_wb_regfile;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_nt ();

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_THROUGH(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_THROUGH(0)) dut_nt (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nt)
    );

    // The stored-read instance sees exactly the same stimulus.
    assign bus_nt.wb_mem_data      = bus.wb_mem_data;
    assign bus_nt.wb_alu_out       = bus.wb_alu_out;
    assign bus_nt.wb_pc_add4       = bus.wb_pc_add4;
    assign bus_nt.wb_write_reg     = bus.wb_write_reg;
    assign bus_nt.wb_reg_write     = bus.wb_reg_write;
    assign bus_nt.wb_mem_to_reg    = bus.wb_mem_to_reg;
    assign bus_nt.rs_addr          = bus.rs_addr;
    assign bus_nt.rt_addr          = bus.rt_addr;
    assign bus_nt.count_load       = bus.count_load;
    assign bus_nt.count_load_value = bus.count_load_value;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] e_wb;
        logic        e_commit;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] wr, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [4:0] rs, input logic [4:0] rt);
        bus.wb_reg_write  = rw;
        bus.wb_write_reg  = wr;
        bus.wb_mem_to_reg = sel;
        bus.wb_alu_out    = alu;
        bus.wb_mem_data   = mem;
        bus.wb_pc_add4    = pc4;
        bus.rs_addr       = rs;
        bus.rt_addr       = rt;
    endtask

    initial begin
        // rw wr sel alu mem pc4 rs rt | wb commit rs rt count(before this edge)
        vecs.push_back('{1'b1, 5'd8, 2'b00, 32'hA, 32'hB, 32'hC, 5'd8, 5'd9, 32'hA, 1'b1, 32'hA, 32'h0, 32'd0});
        vecs.push_back('{1'b0, 5'd8, 2'b00, 32'hA, 32'hB, 32'hC, 5'd8, 5'd8, 32'hA, 1'b0, 32'hA, 32'hA, 32'd1});
        vecs.push_back('{1'b1, 5'd8, 2'b01, 32'hA, 32'hB, 32'hC, 5'd8, 5'd9, 32'hB, 1'b1, 32'hB, 32'h0, 32'd1});
        vecs.push_back('{1'b0, 5'd8, 2'b01, 32'hA, 32'hB, 32'hC, 5'd8, 5'd8, 32'hB, 1'b0, 32'hB, 32'hB, 32'd2});
        vecs.push_back('{1'b1, 5'd8, 2'b10, 32'hA, 32'hB, 32'hC, 5'd8, 5'd9, 32'hC, 1'b1, 32'hC, 32'h0, 32'd2});
        vecs.push_back('{1'b0, 5'd8, 2'b10, 32'hA, 32'hB, 32'hC, 5'd8, 5'd8, 32'hC, 1'b0, 32'hC, 32'hC, 32'd3});
        vecs.push_back('{1'b1, 5'd8, 2'b11, 32'hA, 32'hB, 32'hC, 5'd8, 5'd9, 32'hA, 1'b1, 32'hA, 32'h0, 32'd3});
        vecs.push_back('{1'b0, 5'd8, 2'b11, 32'hA, 32'hB, 32'hC, 5'd8, 5'd8, 32'hA, 1'b0, 32'hA, 32'hA, 32'd4});
        // r0 guard
        vecs.push_back('{1'b1, 5'd0, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 32'd4});
        vecs.push_back('{1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8, 32'h0, 1'b0, 32'h0, 32'hA, 32'd4});
        // r4 = 7, then enable off with other inputs active or unknown
        vecs.push_back('{1'b1, 5'd4, 2'b00, 32'h7, 32'h0, 32'h0, 5'd4, 5'd8, 32'h7, 1'b1, 32'h7, 32'hA, 32'd4});
        vecs.push_back('{1'b0, 5'd4, 2'b01, 32'h99, 32'h99, 32'h99, 5'd4, 5'd4, 32'h99, 1'b0, 32'h7, 32'h7, 32'd5});
        vecs.push_back('{1'b0, 5'd4, 2'b01, 32'hx, 32'hx, 32'hx, 5'd4, 5'd4, 32'hx, 1'b0, 32'h7, 32'h7, 32'd5});
        // back-to-back writes to r4
        vecs.push_back('{1'b1, 5'd4, 2'b00, 32'h1, 32'h0, 32'h0, 5'd4, 5'd5, 32'h1, 1'b1, 32'h1, 32'h0, 32'd5});
        vecs.push_back('{1'b1, 5'd4, 2'b00, 32'h2, 32'h0, 32'h0, 5'd4, 5'd5, 32'h2, 1'b1, 32'h2, 32'h0, 32'd6});
        vecs.push_back('{1'b1, 5'd4, 2'b00, 32'h3, 32'h0, 32'h0, 5'd4, 5'd5, 32'h3, 1'b1, 32'h3, 32'h0, 32'd7});
        vecs.push_back('{1'b0, 5'd4, 2'b00, 32'h0, 32'h0, 32'h0, 5'd4, 5'd4, 32'h0, 1'b0, 32'h3, 32'h3, 32'd8});

        reset = 1'b1;
        bus.count_load       = 1'b0;
        bus.count_load_value = 32'h0;
        drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
        #1;
        check("reset count", bus.commit_count, 32'h0);
        check("reset rs", bus.rs_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rw, vecs[i].wr, vecs[i].sel, vecs[i].alu, vecs[i].mem,
                  vecs[i].pc4, vecs[i].rs, vecs[i].rt);
            #1;
            check($sformatf("vec%0d wb_data", i), bus.wb_data, vecs[i].e_wb);
            check($sformatf("vec%0d wb_commit", i), 32'(bus.wb_commit), 32'(vecs[i].e_commit));
            check($sformatf("vec%0d rs_data", i), bus.rs_data, vecs[i].e_rs);
            check($sformatf("vec%0d rt_data", i), bus.rt_data, vecs[i].e_rt);
            check($sformatf("vec%0d commit_count", i), bus.commit_count, vecs[i].e_cnt);
        end

        // Write-through vs. stored read of r3
        @(negedge clk);
        drive(1'b1, 5'd3, 2'b00, 32'h11, 32'h0, 32'h0, 5'd3, 5'd3);
        @(negedge clk);
        drive(1'b1, 5'd3, 2'b00, 32'h55, 32'h0, 32'h0, 5'd3, 5'd3);
        #1;
        check("bypass wt rs", bus.rs_data, 32'h55);
        check("bypass wt rt", bus.rt_data, 32'h55);
        check("bypass nt rs", bus_nt.rs_data, 32'h11);
        check("bypass nt rt", bus_nt.rt_data, 32'h11);
        @(negedge clk);
        drive(1'b0, 5'd3, 2'b00, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);
        #1;
        check("after edge wt rs", bus.rs_data, 32'h55);
        check("after edge nt rs", bus_nt.rs_data, 32'h55);
        check("after edge nt rt", bus_nt.rt_data, 32'h55);

        // Async reset between edges, with a write pending during reset
        @(negedge clk);
        drive(1'b1, 5'd5, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd5, 2'b00, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
        #1;
        check("r5 before reset", bus.rs_data, 32'h1234);
        #1;
        reset = 1'b1;
        drive(1'b1, 5'd5, 2'b00, 32'h5678, 32'h0, 32'h0, 5'd5, 5'd0);
        #1;
        check("r5 in reset", bus.rs_data, 32'h0);
        check("count in reset", bus.commit_count, 32'h0);
        check("wb_data in reset", bus.wb_data, 32'h5678);
        @(posedge clk);
        #1;
        check("r5 write lost", bus.rs_data, 32'h0);
        check("count held", bus.commit_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("bypass after reset", bus.rs_data, 32'h5678);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd5, 2'b00, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
        #1;
        check("first write after reset", bus.rs_data, 32'h5678);
        check("count after reset", bus.commit_count, 32'd1);

        // Counter wrap from a preloaded value
        @(negedge clk);
        bus.count_load       = 1'b1;
        bus.count_load_value = 32'hFFFF_FFFE;
        @(negedge clk);
        bus.count_load = 1'b0;
        drive(1'b1, 5'd6, 2'b00, 32'h1, 32'h0, 32'h0, 5'd6, 5'd0);
        #1;
        check("count preload", bus.commit_count, 32'hFFFF_FFFE);
        @(negedge clk);
        drive(1'b1, 5'd6, 2'b00, 32'h2, 32'h0, 32'h0, 5'd6, 5'd0);
        #1;
        check("count max", bus.commit_count, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b0, 5'd6, 2'b00, 32'h0, 32'h0, 32'h0, 5'd6, 5'd0);
        #1;
        check("count wrap", bus.commit_count, 32'h0);
        check("count wrap nt", bus_nt.commit_count, 32'h0);
        check("r6 last write", bus.rs_data, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
